// File: rtl/mc_ctrl_fsm_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm_pkg
//   Shared definitions for the multi-cycle control FSM:
//     - state_t    : FSM state enumeration
//     - OP_*       : opcode values decoded in DEC
//     - ALUOP_*    : alu_op output encodings
//     - ctrl_t     : bundle of Moore control outputs
//     - ctrl_decode: state -> control output decode
// -----------------------------------------------------------------------------
package mc_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_IF,
    S_DEC,
    S_ALU,
    S_ALU_WB,
    S_LD_ADDR,
    S_LD_MEM,
    S_LD_WB,
    S_ST_ADDR,
    S_ST_MEM,
    S_MD_RUN,
    S_MD_WB,
    S_TRAP
  } state_t;

  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_MUL = 2;
  localparam int unsigned OP_DIV = 3;
  localparam int unsigned OP_LD  = 4;
  localparam int unsigned OP_ST  = 5;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_MUL = 2'b10;
  localparam logic [1:0] ALUOP_DIV = 2'b11;

  localparam int unsigned   MD_CNT_W   = 8;
  localparam logic [7:0]    MD_CNT_MAX = 8'hFF;

  typedef struct packed {
    logic       we;
    logic       mem_write;
    logic       mem_read;
    logic       ready;
    logic       regsrc;
    logic       ir_update;
    logic       store;
    logic       alusrc;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  // Moore decode of the control outputs for a given state. The ST_MEM exit
  // ready is not included here; it depends on mem_wait and is added at the top.
  function automatic ctrl_t ctrl_decode(input state_t s, input logic [1:0] aop);
    ctrl_t c;
    c = '0;
    case (s)
      S_IF: begin
        c.mem_read  = 1'b1;
        c.regsrc    = 1'b1;
        c.ir_update = 1'b1;
      end
      S_DEC: begin
        c.ir_update = 1'b1;
      end
      S_ALU, S_MD_RUN: begin
        c.regsrc = 1'b1;
        c.alusrc = 1'b1;
        c.alu_op = aop;
      end
      S_ALU_WB, S_MD_WB: begin
        c.regsrc = 1'b1;
        c.alusrc = 1'b1;
        c.alu_op = aop;
        c.we     = 1'b1;
        c.ready  = 1'b1;
      end
      S_LD_ADDR, S_LD_MEM: begin
        c.mem_read = 1'b1;
      end
      S_LD_WB: begin
        c.we    = 1'b1;
        c.ready = 1'b1;
      end
      S_ST_ADDR: begin
        c.store = 1'b1;
      end
      S_ST_MEM: begin
        c.store     = 1'b1;
        c.mem_write = 1'b1;
      end
      S_TRAP: begin
        c.illegal = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_md_timer.sv
// -----------------------------------------------------------------------------
// mc_md_timer
//   8-bit cycle counter for the mul/div execute phase.
//   Ports:
//     clk      - clock, rising edge
//     rst      - asynchronous active-high reset, clears the count
//     clr      - synchronous clear (held while outside MD_RUN)
//     en       - count enable (one increment per MD_RUN cycle)
//     limit    - compare value
//     at_limit - count == limit
//   The count saturates at 255 and never wraps.
// -----------------------------------------------------------------------------
module mc_md_timer
  import mc_ctrl_fsm_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [MD_CNT_W-1:0] limit,
  output logic                at_limit
);

  logic [MD_CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != MD_CNT_MAX)) begin
      count <= count + 8'd1;
    end
  end

  assign at_limit = (count == limit);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm
//   Multi-cycle processor control FSM: fetch, decode, ALU, load, store,
//   iterative mul/div and trap sequencing.
//   Parameters:
//     IW        - instruction width (>= 8)
//     OPW       - opcode width; opcode = instruction[IW-1 -: OPW]
//     MD_CYCLES - mul/div execute cycles in counter mode (1..255)
//     USE_DONE  - 1: mul/div exits on alu_done, 0: fixed cycle count
//     TIMEOUT   - max MD_RUN cycles in handshake mode before trapping (1..255)
//   Ports:
//     clk, rst               - clock, asynchronous active-high reset
//     instruction            - instruction register contents
//     mem_wait               - memory not ready, stalls IF/LD_MEM/ST_MEM
//     alu_done               - mul/div result valid (handshake mode only)
//     we, mem_write, mem_read- register write, memory write, memory read
//     ready                  - instruction retires this cycle
//     regsrc, ir_update,
//     store, alusrc          - datapath selects / IR load enable
//     alu_op                 - 00 add, 01 sub, 10 mul, 11 div
//     alu_start              - pulse on first MD_RUN cycle
//     illegal                - pulse on reserved opcode or mul/div timeout
// -----------------------------------------------------------------------------
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int unsigned IW        = 16,
  parameter int unsigned OPW       = 3,
  parameter int unsigned MD_CYCLES = 27,
  parameter int unsigned USE_DONE  = 0,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instruction,
  input  logic          mem_wait,
  input  logic          alu_done,
  output logic          we,
  output logic          mem_write,
  output logic          mem_read,
  output logic          ready,
  output logic          regsrc,
  output logic          ir_update,
  output logic          store,
  output logic          alusrc,
  output logic [1:0]    alu_op,
  output logic          alu_start,
  output logic          illegal
);

  localparam logic [MD_CNT_W-1:0] MD_LIMIT =
    (USE_DONE != 0) ? MD_CNT_W'(TIMEOUT - 1) : MD_CNT_W'(MD_CYCLES - 1);

  logic [OPW-1:0] opcode;
  logic [31:0]    op_val;
  logic [1:0]     op_lo;
  logic           unused_instr_bits;

  assign opcode = instruction[IW-1 -: OPW];
  assign op_val = 32'(opcode);
  assign op_lo  = opcode[1:0];
  // Operand fields below the opcode belong to the datapath.
  assign unused_instr_bits = ^instruction[IW-OPW-1:0];

  state_t state;
  state_t nxt;
  ctrl_t  ctrl_q;
  logic   alu_start_q;
  logic   md_at_limit;

  mc_md_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (state != S_MD_RUN),
    .en       (state == S_MD_RUN),
    .limit    (MD_LIMIT),
    .at_limit (md_at_limit)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_IF:      if (!mem_wait) nxt = S_DEC;
      S_DEC: begin
        if ((op_val == OP_ADD) || (op_val == OP_SUB))      nxt = S_ALU;
        else if ((op_val == OP_MUL) || (op_val == OP_DIV)) nxt = S_MD_RUN;
        else if (op_val == OP_LD)                          nxt = S_LD_ADDR;
        else if (op_val == OP_ST)                          nxt = S_ST_ADDR;
        else                                               nxt = S_TRAP;
      end
      S_ALU:     nxt = S_ALU_WB;
      S_ALU_WB:  nxt = S_IF;
      S_LD_ADDR: nxt = S_LD_MEM;
      S_LD_MEM:  if (!mem_wait) nxt = S_LD_WB;
      S_LD_WB:   nxt = S_IF;
      S_ST_ADDR: nxt = S_ST_MEM;
      S_ST_MEM:  if (!mem_wait) nxt = S_IF;
      S_MD_RUN: begin
        if (USE_DONE != 0) begin
          // done has priority over a timeout in the same cycle
          if (alu_done)         nxt = S_MD_WB;
          else if (md_at_limit) nxt = S_TRAP;
        end else if (md_at_limit) begin
          nxt = S_MD_WB;
        end
      end
      S_MD_WB:   nxt = S_IF;
      S_TRAP:    nxt = S_IF;
      default:   nxt = S_IF;
    endcase
  end

  // Outputs are decoded from the next state and registered with it, so they
  // are a pure function of the current state with no input-to-output path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IF;
      ctrl_q      <= ctrl_decode(S_IF, ALUOP_ADD);
      alu_start_q <= 1'b0;
    end else begin
      state       <= nxt;
      ctrl_q      <= ctrl_decode(nxt, op_lo);
      alu_start_q <= (nxt == S_MD_RUN) && (state != S_MD_RUN);
    end
  end

  assign we        = ctrl_q.we;
  assign mem_write = ctrl_q.mem_write;
  assign mem_read  = ctrl_q.mem_read;
  assign regsrc    = ctrl_q.regsrc;
  assign ir_update = ctrl_q.ir_update;
  assign store     = ctrl_q.store;
  assign alusrc    = ctrl_q.alusrc;
  assign alu_op    = ctrl_q.alu_op;
  assign illegal   = ctrl_q.illegal;
  assign alu_start = alu_start_q;
  // A store retires on the ST_MEM cycle that memory accepts it; this is the
  // only output that looks at an input in the same cycle.
  assign ready     = ctrl_q.ready | ((state == S_ST_MEM) & ~mem_wait);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

  localparam int TO_H = 10;
  localparam int MDC  = 27;
  localparam logic [11:0] IFV   = 12'h2C0;
  localparam logic [11:0] DECV  = 12'h040;
  localparam logic [11:0] TRAPV = 12'h001;

  logic        clk;
  logic        rst_c, rst_h;
  logic [15:0] instruction;
  logic        mem_wait, alu_done;
  logic        sel;
  logic        exp_on;
  logic [11:0] exp_vec;

  logic        we_c, mw_c, mr_c, rdy_c, rs_c, iru_c, st_c, as_c, start_c, ill_c;
  logic [1:0]  aop_c;
  logic        we_h, mw_h, mr_h, rdy_h, rs_h, iru_h, st_h, as_h, start_h, ill_h;
  logic [1:0]  aop_h;
  logic [11:0] vec_c, vec_h, act_vec;

  int checks = 0;
  int errors = 0;
  int cyc_idx, rdy_cycle, ill_cycle, rdy_cnt, we_cnt, mw_cnt, st_cnt, ill_cnt, run_cnt;

  mc_ctrl_fsm #(.IW(16), .OPW(3), .MD_CYCLES(MDC), .USE_DONE(0), .TIMEOUT(255)) dut_c (
    .clk(clk), .rst(rst_c), .instruction(instruction), .mem_wait(mem_wait),
    .alu_done(alu_done), .we(we_c), .mem_write(mw_c), .mem_read(mr_c),
    .ready(rdy_c), .regsrc(rs_c), .ir_update(iru_c), .store(st_c),
    .alusrc(as_c), .alu_op(aop_c), .alu_start(start_c), .illegal(ill_c)
  );

  mc_ctrl_fsm #(.IW(16), .OPW(3), .MD_CYCLES(MDC), .USE_DONE(1), .TIMEOUT(TO_H)) dut_h (
    .clk(clk), .rst(rst_h), .instruction(instruction), .mem_wait(mem_wait),
    .alu_done(alu_done), .we(we_h), .mem_write(mw_h), .mem_read(mr_h),
    .ready(rdy_h), .regsrc(rs_h), .ir_update(iru_h), .store(st_h),
    .alusrc(as_h), .alu_op(aop_h), .alu_start(start_h), .illegal(ill_h)
  );

  assign vec_c   = {we_c, mw_c, mr_c, rdy_c, rs_c, iru_c, st_c, as_c, aop_c, start_c, ill_c};
  assign vec_h   = {we_h, mw_h, mr_h, rdy_h, rs_h, iru_h, st_h, as_h, aop_h, start_h, ill_h};
  assign act_vec = sel ? vec_h : vec_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Output order: we mem_write mem_read ready regsrc ir_update store alusrc alu_op alu_start illegal
  function automatic logic [11:0] ov(input int we_, mw_, mr_, rdy_, rs_, iru_, st_, as_,
                                     aop_, start_, ill_);
    return {we_[0], mw_[0], mr_[0], rdy_[0], rs_[0], iru_[0], st_[0], as_[0],
            aop_[1:0], start_[0], ill_[0]};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  always @(negedge clk) begin
    if (exp_on) begin
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("FAIL outs_%s t=%0t cyc=%0d act=%b exp=%b", sel ? "hs" : "cnt",
                 $time, cyc_idx, act_vec, exp_vec);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, expv);
    end
  endtask

  // Entered at posedge+1; drives one cycle, leaves at the next posedge+1.
  task automatic cyc(input logic [11:0] e, input logic mw, input logic dn);
    logic [11:0] a;
    mem_wait = mw;
    alu_done = dn;
    exp_vec  = e;
    exp_on   = 1'b1;
    @(negedge clk);
    cyc_idx++;
    a = act_vec;
    if (a[8] && rdy_cycle == 0) rdy_cycle = cyc_idx;
    if (a[0] && ill_cycle == 0) ill_cycle = cyc_idx;
    rdy_cnt += int'(a[8]);
    we_cnt  += int'(a[11]);
    mw_cnt  += int'(a[10]);
    st_cnt  += int'(a[1]);
    ill_cnt += int'(a[0]);
    run_cnt += int'(a[4] && !a[11]);
    @(posedge clk);
    #1;
  endtask

  // Expected trace of one instruction from the latency/output rules.
  task automatic run_instr(input int op, input int ifs, input int ms, input int dat);
    logic [15:0] ins;
    int aop, n;
    ins = 16'($urandom);
    ins[15:13] = 3'(op);
    instruction = ins;
    aop = op & 3;
    cyc_idx = 0; rdy_cycle = 0; ill_cycle = 0; rdy_cnt = 0; we_cnt = 0;
    mw_cnt = 0; st_cnt = 0; ill_cnt = 0; run_cnt = 0;
    for (int i = 0; i < ifs; i++) cyc(IFV, 1'b1, rb());
    cyc(IFV, 1'b0, rb());
    cyc(DECV, rb(), rb());
    case (op)
      0, 1: begin
        cyc(ov(0,0,0,0,1,0,0,1,aop,0,0), rb(), rb());
        cyc(ov(1,0,0,1,1,0,0,1,aop,0,0), rb(), rb());
      end
      2, 3: begin
        if (!sel) begin
          for (int k = 1; k <= MDC; k++)
            cyc(ov(0,0,0,0,1,0,0,1,aop,int'(k == 1),0), rb(), rb());
          cyc(ov(1,0,0,1,1,0,0,1,aop,0,0), rb(), rb());
        end else begin
          n = (dat <= TO_H) ? dat : TO_H;
          for (int k = 1; k <= n; k++)
            cyc(ov(0,0,0,0,1,0,0,1,aop,int'(k == 1),0), rb(), k == dat);
          if (dat <= TO_H) cyc(ov(1,0,0,1,1,0,0,1,aop,0,0), rb(), rb());
          else             cyc(TRAPV, rb(), rb());
        end
      end
      4: begin
        cyc(ov(0,0,1,0,0,0,0,0,0,0,0), rb(), rb());
        for (int i = 0; i < ms; i++) cyc(ov(0,0,1,0,0,0,0,0,0,0,0), 1'b1, rb());
        cyc(ov(0,0,1,0,0,0,0,0,0,0,0), 1'b0, rb());
        cyc(ov(1,0,0,1,0,0,0,0,0,0,0), rb(), rb());
      end
      5: begin
        cyc(ov(0,0,0,0,0,0,1,0,0,0,0), rb(), rb());
        for (int i = 0; i < ms; i++) cyc(ov(0,1,0,0,0,0,1,0,0,0,0), 1'b1, rb());
        cyc(ov(0,1,0,1,0,0,1,0,0,0,0), 1'b0, rb());
      end
      default: cyc(TRAPV, rb(), rb());
    endcase
  endtask

  initial begin
    rst_c = 1'b1; rst_h = 1'b1; sel = 1'b0; exp_on = 1'b0; exp_vec = '0;
    instruction = '0; mem_wait = 1'b0; alu_done = 1'b0;
    cyc_idx = 0;
    @(posedge clk); #1;
    chk("reset_outs_cnt", int'(vec_c), 32'h2C0);
    chk("reset_outs_hs", int'(vec_h), 32'h2C0);
    cyc(IFV, 1'b1, 1'b1);
    cyc(IFV, 1'b0, 1'b0);
    rst_c = 1'b0;

    // counter-mode DUT, directed
    run_instr(0, 0, 0, 0);
    chk("add_ready_cycle", rdy_cycle, 4);
    chk("add_we_cycles", we_cnt, 1);
    run_instr(2, 0, 0, 0);
    chk("mul_ready_cycle", rdy_cycle, 30);
    chk("mul_start_pulses", st_cnt, 1);
    chk("mul_run_cycles", run_cnt, 27);
    run_instr(4, 0, 3, 0);
    chk("ld_stall_ready_cycle", rdy_cycle, 8);
    run_instr(5, 0, 3, 0);
    chk("st_stall_mem_write_cycles", mw_cnt, 4);
    chk("st_stall_ready_pulses", rdy_cnt, 1);
    chk("st_stall_ready_cycle", rdy_cycle, 7);
    run_instr(7, 0, 0, 0);
    chk("op7_illegal_cycle", ill_cycle, 3);
    chk("op7_we_cycles", we_cnt, 0);
    chk("op7_mem_write_cycles", mw_cnt, 0);
    run_instr(1, 1, 0, 0);
    chk("sub_ifstall_ready_cycle", rdy_cycle, 5);

    // reset in the middle of MD_RUN
    instruction = 16'h4000;
    cyc_idx = 0;
    cyc(IFV, 1'b0, 1'b0);
    cyc(DECV, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) cyc(ov(0,0,0,0,1,0,0,1,2,int'(k == 1),0), 1'b0, 1'b0);
    rst_c = 1'b1;
    #1;
    chk("rst_mid_outs", int'(vec_c), 32'h2C0);
    chk("rst_mid_count", int'(dut_c.u_timer.count), 0);
    cyc(IFV, 1'b0, 1'b0);
    rst_c = 1'b0;
    run_instr(2, 0, 0, 0);
    chk("mul_after_rst_ready_cycle", rdy_cycle, 30);
    chk("mul_after_rst_start_pulses", st_cnt, 1);

    for (int i = 0; i < 40; i++)
      run_instr($urandom_range(0, 7), $urandom_range(0, 2), $urandom_range(0, 3), 0);

    // switch to handshake-mode DUT
    rst_c = 1'b1;
    sel   = 1'b1;
    rst_h = 1'b0;
    run_instr(3, 0, 0, 5);
    chk("div_done5_ready_cycle", rdy_cycle, 8);
    chk("div_done5_we_cycles", we_cnt, 1);
    run_instr(3, 0, 0, 11);
    chk("div_timeout_illegal_pulses", ill_cnt, 1);
    chk("div_timeout_illegal_cycle", ill_cycle, 13);
    chk("div_timeout_we_cycles", we_cnt, 0);
    run_instr(2, 0, 0, 10);
    chk("mul_done_at_limit_ready_cycle", rdy_cycle, 13);
    chk("mul_done_at_limit_illegal", ill_cnt, 0);

    for (int i = 0; i < 40; i++)
      run_instr($urandom_range(0, 7), $urandom_range(0, 2), $urandom_range(0, 3),
                $urandom_range(1, 11));

    exp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
Parameters:
REQ-001 IW, 16, instruction width in bits (IW >= 8).
REQ-002 OPW, 3, opcode width; opcode = instruction[IW-1 -: OPW].
REQ-003 MD_CYCLES, 27, mul/div execute cycles in counter mode (1..255).
REQ-004 USE_DONE, 0, selects mul/div exit: 1 = alu_done handshake, 0 = fixed counter.
REQ-005 TIMEOUT, 255, max MD_RUN cycles in handshake mode before abort (1..255).

Ports (name, direction, width, meaning):
REQ-006 clk, input, 1, single clock; all state on rising edge.
REQ-007 rst, input, 1, reset; asynchronous, active-high.
REQ-008 instruction, input, IW, current instruction register contents.
REQ-009 mem_wait, input, 1, memory not ready; stalls memory states.
REQ-010 alu_done, input, 1, iterative mul/div result valid; sampled only in MD_RUN with USE_DONE=1.
REQ-011 we, mem_write, mem_read, output, 1 each, register-file write, memory write, memory read.
REQ-012 ready, output, 1, instruction retires this cycle.
REQ-013 regsrc, ir_update, store, alusrc, output, 1 each, datapath mux selects and IR load enable.
REQ-014 alu_op, output, 2, 00 add, 01 sub, 10 mul, 11 div.
REQ-015 alu_start, output, 1, one-cycle pulse on the first MD_RUN cycle.
REQ-016 illegal, output, 1, one-cycle pulse on a reserved opcode or mul/div timeout.

Function
REQ-017 States: IF, DEC, ALU, ALU_WB, LD_ADDR, LD_MEM, LD_WB, ST_ADDR, ST_MEM, MD_RUN, MD_WB, TRAP.
REQ-018 Outputs are Moore, decoded from state (plus first-cycle flag for alu_start); no input-to-output combinational path.
REQ-019 IF: mem_read=1, regsrc=1, ir_update=1, others 0; holds while mem_wait=1, otherwise -> DEC.
REQ-020 DEC: ir_update=1, others 0; opcode 0/1 -> ALU, 2/3 -> MD_RUN, 4 -> LD_ADDR, 5 -> ST_ADDR, any other value (all of 6..2^OPW-1) -> TRAP.
REQ-021 ALU: regsrc=1, alusrc=1, alu_op=opcode[1:0]; -> ALU_WB. ALU_WB: same plus we=1, ready=1; -> IF.
REQ-022 LD_ADDR: mem_read=1; -> LD_MEM. LD_MEM: mem_read=1; holds while mem_wait. LD_WB: we=1, ready=1; -> IF.
REQ-023 ST_ADDR: store=1; -> ST_MEM. ST_MEM: store=1, mem_write=1; holds while mem_wait; ready=1 only on the exit cycle (mem_wait=0); -> IF.
REQ-024 MD_RUN: regsrc=1, alusrc=1, alu_op=opcode[1:0]; 8-bit counter cleared on entry, +1 per MD_RUN cycle.
REQ-025 Counter mode: exit to MD_WB when count == MD_CYCLES-1, giving exactly MD_CYCLES MD_RUN cycles.
REQ-026 Handshake mode: exit to MD_WB the cycle alu_done=1; if count reaches TIMEOUT-1 without alu_done, -> TRAP instead.
REQ-027 alu_done asserted in the same cycle as the timeout limit: done wins.
REQ-028 MD_WB: MD_RUN outputs plus we=1, ready=1; -> IF.
REQ-029 TRAP: all outputs 0 except illegal=1; no register or memory write; -> IF.
REQ-030 Instruction latency without stalls: ALU 4, LD 5, ST 4, MD MD_CYCLES+3 cycles; each mem_wait cycle adds 1.
REQ-031 Counter saturates at 255 and never wraps.

Reset
REQ-032 rst=1 forces state IF and clears the counter and first-cycle flag asynchronously, from any state including mid-MD_RUN or a stalled memory state.
REQ-033 Output values during and after reset: IF values (mem_read=1, regsrc=1, ir_update=1, all others 0, alu_op=00).
REQ-034 The first IF after reset deassertion starts on the next rising clk.

Structure
REQ-035 Shared package holds the state enumeration, opcode constants (OP_ADD..OP_ST) and alu_op encodings.
REQ-036 One sub-module, mc_md_timer: the 8-bit MD_RUN counter with clear, enable, limit compare and saturation.

Verification
REQ-037 ADD opcode 000, mem_wait=0 -> ready on cycle 4, we=1 only in ALU_WB, alu_op=00.
REQ-038 MUL, USE_DONE=0, MD_CYCLES=27 -> alu_start on exactly 1 cycle, 27 MD_RUN cycles, ready on cycle 30.
REQ-039 DIV, USE_DONE=1, alu_done after 5 cycles -> MD_WB next cycle; with alu_done never asserted and TIMEOUT=10 -> illegal pulse, we stays 0.
REQ-040 LD with mem_wait high 3 cycles in LD_MEM -> ready on cycle 8; ST with the same stall -> mem_write held for 4 cycles, one ready pulse.
REQ-041 Opcode 111 -> illegal pulse in cycle 3, no we or mem_write, fetch resumes.
REQ-042 rst asserted mid-MD_RUN -> immediate IF outputs, counter 0; the next MUL again takes full latency.
